// File: rtl/noc_master_pkg.sv
// Shared constants for the NOC_MASTER packet sequencer: ROM word fields, opcodes, FSM states.
package noc_master_pkg;

  localparam int OPC_HI    = 71;
  localparam int OPC_LO    = 68;
  localparam int PAYLOAD_W = 64;
  localparam int WCNT_W    = 16;

  localparam logic [3:0] OP_DATA = 4'h0;
  localparam logic [3:0] OP_LAST = 4'h1;
  localparam logic [3:0] OP_WAIT = 4'h2;
  localparam logic [3:0] OP_END  = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SEND = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/noc_pkt_word_dec.sv
// Combinational decode of one 72-bit ROM word into opcode flags and the WAIT length.
module noc_pkt_word_dec
  import noc_master_pkg::*;
#(
  parameter int DATA_W = 72
) (
  input  logic [DATA_W-1:0] rom_data,
  output logic              is_data,
  output logic              is_last,
  output logic              is_wait,
  output logic              is_end,
  output logic              bad_op,
  output logic [WCNT_W-1:0] wait_cnt
);

  logic [3:0] opc;
  logic       unused_bits;

  assign opc         = rom_data[OPC_HI:OPC_LO];
  assign unused_bits = ^rom_data[OPC_LO-1:WCNT_W];

  // Opcode flags; unknown opcodes terminate like END but are flagged. WAIT 0 is stretched to 1.
  always_comb begin
    is_data  = 1'b0;
    is_last  = 1'b0;
    is_wait  = 1'b0;
    is_end   = 1'b0;
    bad_op   = 1'b0;
    wait_cnt = (rom_data[WCNT_W-1:0] == '0) ? WCNT_W'(1) : rom_data[WCNT_W-1:0];
    case (opc)
      OP_DATA: is_data = 1'b1;
      OP_LAST: is_last = 1'b1;
      OP_WAIT: is_wait = 1'b1;
      OP_END:  is_end  = 1'b1;
      default: begin
        is_end = 1'b1;
        bad_op = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/noc_master_pkt_seq.sv
// ROM-driven flit sequencer for the NOC_MASTER stimulus path.
//
//  state | meaning
//  IDLE  | after reset, waiting for start
//  LOAD  | decode the ROM word at addr_inc, no flit held
//  SEND  | flit presented, held until noc_ready; decodes the next word on accept
//  WAIT  | idle bubble, wcnt counts down to 1
//  DONE  | finished (END, bad opcode, overrun or stop); done held until start
module noc_master_pkt_seq
  import noc_master_pkg::*;
#(
  parameter int                ADDR_W     = 48,
  parameter int                DATA_W     = 72,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter int unsigned       MAX_WORDS  = 65536
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic                 start,
  input  logic                 stop_req,
  output logic [ADDR_W-1:0]    addr_inc,
  input  logic [DATA_W-1:0]    rom_data,
  output logic                 noc_valid,
  output logic [PAYLOAD_W-1:0] noc_data,
  output logic                 noc_last,
  input  logic                 noc_ready,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          pkt_cnt,
  output logic                 err_overrun,
  output logic                 err_opcode
);

  // One past the last legal word; reaching it means the ROM ran out without END.
  localparam logic [ADDR_W-1:0] END_ADDR = START_ADDR + ADDR_W'(MAX_WORDS);

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   valid_q, valid_d;
  logic [PAYLOAD_W-1:0]   data_q, data_d;
  logic                   last_q, last_d;
  logic [WCNT_W-1:0]      wcnt_q, wcnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [15:0]            pkt_q, pkt_d;
  logic                   ovr_q, ovr_d;
  logic                   opc_q, opc_d;

  logic                   is_data, is_last, is_wait, is_end, bad_op;
  logic [WCNT_W-1:0]      wait_cnt;
  logic                   accept, at_limit, do_decode;

  noc_pkt_word_dec #(.DATA_W(DATA_W)) u_dec (
    .rom_data (rom_data),
    .is_data  (is_data),
    .is_last  (is_last),
    .is_wait  (is_wait),
    .is_end   (is_end),
    .bad_op   (bad_op),
    .wait_cnt (wait_cnt)
  );

  assign accept   = valid_q & noc_ready;
  assign at_limit = (addr_q == END_ADDR);

  // Next-state and output-register logic; LOAD and an accepted SEND share one decode path.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    valid_d   = valid_q;
    data_d    = data_q;
    last_d    = last_q;
    wcnt_d    = wcnt_q;
    pkt_d     = pkt_q;
    ovr_d     = ovr_q;
    opc_d     = opc_q;
    do_decode = 1'b0;

    if (accept && last_q && (pkt_q != 16'hFFFF)) pkt_d = pkt_q + 16'd1;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (stop_req) state_d = ST_DONE;
        else if (at_limit) begin
          ovr_d   = 1'b1;
          state_d = ST_DONE;
        end else do_decode = 1'b1;
      end
      ST_SEND: begin
        if (accept) begin
          valid_d = 1'b0;
          if (stop_req) state_d = ST_DONE;
          else if (at_limit) begin
            ovr_d   = 1'b1;
            state_d = ST_DONE;
          end else do_decode = 1'b1;
        end
      end
      ST_WAIT: begin
        wcnt_d = wcnt_q - WCNT_W'(1);
        if (stop_req) state_d = ST_DONE;
        else if (wcnt_q <= WCNT_W'(1)) state_d = ST_LOAD;
      end
      ST_DONE: begin
        if (start) begin
          addr_d  = START_ADDR;
          pkt_d   = '0;
          ovr_d   = 1'b0;
          opc_d   = 1'b0;
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_decode) begin
      if (is_data || is_last) begin
        data_d  = rom_data[PAYLOAD_W-1:0];
        last_d  = is_last;
        valid_d = 1'b1;
        addr_d  = addr_q + ADDR_W'(1);
        state_d = ST_SEND;
      end else if (is_wait) begin
        wcnt_d  = wait_cnt;
        addr_d  = addr_q + ADDR_W'(1);
        state_d = ST_WAIT;
      end else if (is_end) begin
        opc_d   = opc_q | bad_op;
        state_d = ST_DONE;
      end
    end

    busy_d = (state_d == ST_LOAD) || (state_d == ST_SEND) || (state_d == ST_WAIT);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q <= ST_IDLE;
      addr_q  <= START_ADDR;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      wcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pkt_q   <= '0;
      ovr_q   <= 1'b0;
      opc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      wcnt_q  <= wcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pkt_q   <= pkt_d;
      ovr_q   <= ovr_d;
      opc_q   <= opc_d;
    end
  end

  assign addr_inc    = addr_q;
  assign noc_valid   = valid_q;
  assign noc_data    = data_q;
  assign noc_last    = last_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pkt_cnt     = pkt_q;
  assign err_overrun = ovr_q;
  assign err_opcode  = opc_q;

endmodule

// File: tb/tb_noc_master_pkt_seq.sv
// Self-checking bench: table of ROM programs plus hand-written corner sequences; flits scoreboarded.
module tb_noc_master_pkt_seq;

  localparam logic [47:0] START = 48'h10;

  logic        clk = 1'b0;
  logic        rst_, start, stop_req, noc_ready;
  logic [47:0] addr_inc;
  logic [71:0] rom_data;
  logic        noc_valid, noc_last, busy, done, err_overrun, err_opcode;
  logic [63:0] noc_data;
  logic [15:0] pkt_cnt;

  logic [71:0] rom [8];
  logic [47:0] rom_off;
  assign rom_off  = addr_inc - START;
  assign rom_data = rom[rom_off[2:0]];

  always #5 clk = ~clk;

  noc_master_pkt_seq #(
    .ADDR_W(48), .DATA_W(72), .START_ADDR(START), .MAX_WORDS(4)
  ) dut (
    .clk(clk), .rst_(rst_), .start(start), .stop_req(stop_req),
    .addr_inc(addr_inc), .rom_data(rom_data),
    .noc_valid(noc_valid), .noc_data(noc_data), .noc_last(noc_last), .noc_ready(noc_ready),
    .busy(busy), .done(done), .pkt_cnt(pkt_cnt),
    .err_overrun(err_overrun), .err_opcode(err_opcode)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [71:0] mk(input logic [3:0] op, input logic [63:0] p);
    return {op, 4'h5, p};
  endfunction

  // scoreboard: {last, payload}
  logic [64:0] exp_q[$];
  int          n_flits, gap, max_gap;
  bit          seen_flit;
  bit          prev_hold = 1'b0;
  logic [63:0] prev_data;
  logic        prev_last;

  // Negedge monitor: pops expected flits on handshakes, checks stalled flits stay put, measures bubbles.
  always @(negedge clk) begin
    logic [64:0] e;
    if (prev_hold) begin
      chk("hold_valid", {63'd0, noc_valid}, 64'd1);
      chk("hold_data", noc_data, prev_data);
      chk("hold_last", {63'd0, noc_last}, {63'd0, prev_last});
    end
    if (rst_ && noc_valid) begin
      if (seen_flit && gap > max_gap) max_gap = gap;
      gap = 0;
      if (noc_ready) begin
        n_flits++;
        seen_flit = 1'b1;
        if (exp_q.size() == 0) chk("unexpected_flit", noc_data, 64'hBAD);
        else begin
          e = exp_q.pop_front();
          chk("flit_data", noc_data, e[63:0]);
          chk("flit_last", {63'd0, noc_last}, {63'd0, e[64]});
        end
      end
    end else if (seen_flit) gap++;
    prev_hold = rst_ && noc_valid && !noc_ready;
    prev_data = noc_data;
    prev_last = noc_last;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats;
    n_flits = 0; gap = 0; max_gap = 0; seen_flit = 1'b0;
  endtask

  task automatic set_rom(input logic [3:0][71:0] w);
    for (int i = 0; i < 4; i++) rom[i] = w[i];
  endtask

  // Reference walk of a program: flits in order until END or an unknown opcode.
  task automatic push_exp(input logic [3:0][71:0] w);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] op;
      op = w[i][71:68];
      if (op == 4'h0 || op == 4'h1) exp_q.push_back({op == 4'h1, w[i][63:0]});
      else if (op != 4'h2) break;
    end
  endtask

  task automatic wait_done(input string nm, input logic [3:0] rdy);
    bit ok = 1'b0;
    for (int c = 1; c < 300; c++) begin
      noc_ready = rdy[c % 4];
      if (done) begin ok = 1'b1; break; end
      tick;
    end
    chk({nm, "_timeout"}, {63'd0, ok}, 64'd1);
  endtask

  typedef struct {
    logic [3:0][71:0] w;
    logic [3:0]       rdy;
    int               flits, pkt, aoff, gap;
    bit               ovr, opc;
  } vec_t;

  vec_t vecs[9];

  task automatic set_vec(input int r, input logic [71:0] w0, w1, w2, w3, input logic [3:0] rdy,
                         input int flits, pkt, input bit ovr, opc, input int aoff, g);
    vecs[r].w = {w3, w2, w1, w0};
    vecs[r].rdy = rdy; vecs[r].flits = flits; vecs[r].pkt = pkt;
    vecs[r].ovr = ovr; vecs[r].opc = opc; vecs[r].aoff = aoff; vecs[r].gap = g;
  endtask

  logic [71:0] wa, wb, wc, wx, wy, wend;
  logic [3:0][71:0] prog1;

  initial begin
    wa = mk(4'h0, 64'h1111_0000_0000_000A);
    wb = mk(4'h0, 64'h2222_0000_0000_000B);
    wc = mk(4'h1, 64'h3333_0000_0000_000C);
    wx = mk(4'h1, 64'h4444_0000_0000_00F1);
    wy = mk(4'h1, 64'h5555_0000_0000_00F2);
    wend = mk(4'hF, 64'h0);
    prog1 = {wend, wc, wb, wa};
    for (int i = 4; i < 8; i++) rom[i] = mk(4'h0, 64'hDEAD_0000_0000_0000 | 64'(i));

    //          w0                w1                      w2                w3               rdy     fl pk ov op ao gap
    set_vec(0, wa,               wb,                     wc,               wend,            4'hF,    3, 1, 0, 0, 3, 0);
    set_vec(1, wa,               wb,                     wc,               wend,            4'b1010, 3, 1, 0, 0, 3, 0);
    set_vec(2, wx,               mk(4'h2, 64'd5),        wy,               wend,            4'hF,    2, 2, 0, 0, 3, 6);
    set_vec(3, wx,               mk(4'h2, 64'd0),        wy,               wend,            4'hF,    2, 2, 0, 0, 3, 2);
    set_vec(4, wa,               wb,                     mk(4'h0, 64'h77), mk(4'h0, 64'h88), 4'hF,   4, 0, 1, 0, 4, 0);
    set_vec(5, wa,               wc,                     mk(4'h7, 64'h99), wend,            4'hF,    2, 1, 0, 1, 2, 0);
    set_vec(6, wx,               wy,                     wc,               wx,              4'b0110, 4, 4, 1, 0, 4, 0);
    set_vec(7, wend,             wa,                     wb,               wc,              4'hF,    0, 0, 0, 0, 0, 0);
    set_vec(8, wx,               mk(4'h2, 64'hABCD_0000_0000_0003), wy,    wend,            4'hF,    2, 2, 0, 0, 3, 4);

    rst_ = 1'b0; start = 1'b0; stop_req = 1'b0; noc_ready = 1'b0;
    set_rom(prog1);
    clear_stats();
    tick; tick;

    // power-up reset values
    @(negedge clk);
    chk("rst_addr", {16'd0, addr_inc}, {16'd0, START});
    chk("rst_valid", {63'd0, noc_valid}, 64'd0);
    chk("rst_data", noc_data, 64'd0);
    chk("rst_busy_done", {62'd0, busy, done}, 64'd0);
    chk("rst_pkt_err", {46'd0, pkt_cnt, err_overrun, err_opcode}, 64'd0);
    tick;
    rst_ = 1'b1;
    tick;

    // start together with stop in IDLE: goes to LOAD, then stop lands in DONE without a flit
    start = 1'b1; stop_req = 1'b1;
    tick;
    start = 1'b0;
    @(negedge clk);
    chk("ss_busy", {62'd0, busy, done}, 64'd2);
    tick;
    @(negedge clk);
    chk("ss_done", {62'd0, done, noc_valid}, 64'd2);
    chk("ss_addr", {16'd0, addr_inc}, {16'd0, START});
    stop_req = 1'b0;
    tick;

    // start -> LOAD -> first flit two cycles later, then back-to-back
    push_exp(prog1);
    clear_stats();
    noc_ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    @(negedge clk);
    chk("lat_n1_valid", {63'd0, noc_valid}, 64'd0);
    tick;
    @(negedge clk);
    chk("lat_n2_data", {noc_valid ? noc_data : 64'd0}, wa[63:0]);
    tick;
    @(negedge clk);
    chk("lat_n3_data", {noc_valid ? noc_data : 64'd0}, wb[63:0]);
    tick;
    @(negedge clk);
    chk("lat_n4_data", {noc_valid ? noc_data : 64'd0}, wc[63:0]);
    tick;
    @(negedge clk);
    chk("lat_n5_end", {61'd0, noc_valid, done, pkt_cnt[0]}, 64'd3);

    // table of ROM programs
    for (int r = 0; r < 9; r++) begin
      tick;
      set_rom(vecs[r].w);
      push_exp(vecs[r].w);
      clear_stats();
      noc_ready = vecs[r].rdy[0]; start = 1'b1;
      tick;
      start = 1'b0;
      wait_done($sformatf("row%0d", r), vecs[r].rdy);
      @(negedge clk);
      chk($sformatf("row%0d_pkt", r), {48'd0, pkt_cnt}, 64'(vecs[r].pkt));
      chk($sformatf("row%0d_ovr", r), {63'd0, err_overrun}, {63'd0, vecs[r].ovr});
      chk($sformatf("row%0d_opc", r), {63'd0, err_opcode}, {63'd0, vecs[r].opc});
      chk($sformatf("row%0d_addr", r), {16'd0, addr_inc}, {16'd0, START + 48'(vecs[r].aoff)});
      chk($sformatf("row%0d_flits", r), 64'(n_flits), 64'(vecs[r].flits));
      chk($sformatf("row%0d_gap", r), 64'(max_gap), 64'(vecs[r].gap));
      chk($sformatf("row%0d_left", r), 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end

    // stop while flit 2 is stalled (start during busy is ignored), then restart
    tick;
    set_rom(prog1);
    exp_q.push_back({1'b0, wa[63:0]});
    exp_q.push_back({1'b0, wb[63:0]});
    clear_stats();
    noc_ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    noc_ready = 1'b0; stop_req = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    @(negedge clk);
    chk("stop_hold_data", {noc_valid ? noc_data : 64'd0}, wb[63:0]);
    chk("stop_hold_busy", {62'd0, busy, done}, 64'd2);
    tick;
    noc_ready = 1'b1;
    tick;
    @(negedge clk);
    chk("stop_done", {61'd0, done, noc_valid, busy}, 64'd4);
    stop_req = 1'b0;
    repeat (4) tick;
    chk("stop_flits", 64'(n_flits), 64'd2);
    chk("stop_left", 64'(exp_q.size()), 64'd0);
    chk("stop_pkt", {48'd0, pkt_cnt}, 64'd0);
    push_exp(prog1);
    clear_stats();
    start = 1'b1;
    tick;
    start = 1'b0;
    @(negedge clk);
    chk("restart_state", {46'd0, pkt_cnt, busy, done}, 64'd2);
    wait_done("restart", 4'hF);
    @(negedge clk);
    chk("restart_pkt", {48'd0, pkt_cnt}, 64'd1);
    chk("restart_flits", 64'(n_flits), 64'd3);
    chk("restart_left", 64'(exp_q.size()), 64'd0);

    // reset while a flit is stalled in SEND
    tick;
    set_rom({wend, wend, wb, wx});
    push_exp({wend, wend, wb, wx});
    clear_stats();
    noc_ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    noc_ready = 1'b0;
    @(negedge clk);
    chk("mid_pre", {46'd0, pkt_cnt, noc_valid, busy}, 64'h7);
    tick;
    rst_ = 1'b0;
    tick;
    @(negedge clk);
    chk("mid_rst_valid", {62'd0, noc_valid, noc_last}, 64'd0);
    chk("mid_rst_data", noc_data, 64'd0);
    chk("mid_rst_addr", {16'd0, addr_inc}, {16'd0, START});
    chk("mid_rst_misc", {44'd0, pkt_cnt, busy, done, err_overrun, err_opcode}, 64'd0);
    exp_q.delete();
    tick;
    rst_ = 1'b1;
    repeat (2) tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
